// File: rtl/volatility_pkg.sv
// Shared constants and types for the per-stock
// volatility buffer read and write controllers.
package volatility_pkg;

  localparam int NUM_STOCKS  = 4;
  localparam int BUFFER_SIZE = 20;
  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_W      =
    $clog2(NUM_STOCKS * BUFFER_SIZE);
  localparam int SID_W       = $clog2(NUM_STOCKS);

  typedef logic [SID_W-1:0]  stock_id_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/volatility_wr_tracker.sv
// Mirrors the writer's per-stock write pointer and
// fill level; reports oldest slot for one stock.
module volatility_wr_tracker #(
  parameter  int NUM_STOCKS  = 4,
  parameter  int BUFFER_SIZE = 20,
  localparam int SW = $clog2(NUM_STOCKS),
  localparam int IW = $clog2(BUFFER_SIZE),
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_valid,
  input  logic [SW-1:0] i_wr_stock_id,
  input  logic [SW-1:0] i_q_stock_id,
  output logic [IW-1:0] o_q_oldest,
  output logic [CW-1:0] o_q_fill
);

  logic [IW-1:0] wr_ptr_q [NUM_STOCKS];
  logic [IW-1:0] wr_ptr_d [NUM_STOCKS];
  logic [CW-1:0] fill_q   [NUM_STOCKS];
  logic [CW-1:0] fill_d   [NUM_STOCKS];

  // advance pointer (wrapping) and saturate fill
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (i_wr_valid) begin
      if (wr_ptr_q[i_wr_stock_id] ==
          IW'(BUFFER_SIZE - 1))
        wr_ptr_d[i_wr_stock_id] = '0;
      else
        wr_ptr_d[i_wr_stock_id] =
          wr_ptr_q[i_wr_stock_id] + IW'(1);
      if (fill_q[i_wr_stock_id] !=
          CW'(BUFFER_SIZE))
        fill_d[i_wr_stock_id] =
          fill_q[i_wr_stock_id] + CW'(1);
    end
  end

  // tracking state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wr_ptr_q[s] <= '0;
        fill_q[s]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // oldest slot: 0 until the region has wrapped
  always_comb begin
    o_q_fill   = fill_q[i_q_stock_id];
    o_q_oldest = '0;
    if (fill_q[i_q_stock_id] == CW'(BUFFER_SIZE))
      o_q_oldest = wr_ptr_q[i_q_stock_id];
  end

endmodule

// File: rtl/volatility_rd_ctrl.sv
// Read-side controller: walks one stock's region
// oldest-to-newest and streams samples out.
module volatility_rd_ctrl #(
  parameter  int NUM_STOCKS  = 4,
  parameter  int BUFFER_SIZE = 20,
  parameter  int DATA_WIDTH  = 32,
  localparam int ADDR_W =
    $clog2(NUM_STOCKS * BUFFER_SIZE),
  localparam int SW = $clog2(NUM_STOCKS),
  localparam int IW = $clog2(BUFFER_SIZE),
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_valid,
  input  logic [SW-1:0]         i_wr_stock_id,
  input  logic                  i_rd_req,
  input  logic [SW-1:0]         i_rd_stock_id,
  output logic                  o_rd_ready,
  output logic                  o_mem_rd_en,
  output logic [ADDR_W-1:0]     o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic                  o_sample_last,
  output logic [CW-1:0]         o_count,
  output logic                  o_done
);

  import volatility_pkg::*;

  function automatic logic [IW-1:0] inc_wrap(
    input logic [IW-1:0] i
  );
    logic [IW:0] s;
    s = {1'b0, i} + (IW+1)'(1);
    if (s >= (IW+1)'(BUFFER_SIZE))
      s = s - (IW+1)'(BUFFER_SIZE);
    return s[IW-1:0];
  endfunction

  logic [IW-1:0] trk_oldest;
  logic [CW-1:0] trk_fill;

  volatility_wr_tracker #(
    .NUM_STOCKS  (NUM_STOCKS),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_trk (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_wr_valid    (i_wr_valid),
    .i_wr_stock_id (i_wr_stock_id),
    .i_q_stock_id  (i_rd_stock_id),
    .o_q_oldest    (trk_oldest),
    .o_q_fill      (trk_fill)
  );

  rd_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_en_q, rd_en_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          empty_q, empty_d;

  logic          same_wr;
  logic          full;
  logic [CW-1:0] acc_n;
  logic [IW-1:0] acc_start;
  logic [ADDR_W-1:0] acc_base;

  // window snapshot, folding in a same-cycle write
  always_comb begin
    same_wr   = i_wr_valid &&
                (i_wr_stock_id == i_rd_stock_id);
    full      = (trk_fill == CW'(BUFFER_SIZE));
    acc_n     = trk_fill;
    acc_start = trk_oldest;
    if (same_wr && !full)
      acc_n = trk_fill + CW'(1);
    if (same_wr && full)
      acc_start = inc_wrap(trk_oldest);
    acc_base  = ADDR_W'(i_rd_stock_id) *
                ADDR_W'(BUFFER_SIZE);
  end

  // FSM next state, address walk, framing
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    count_d = count_q;
    rd_en_d = 1'b0;
    vld_d   = rd_en_q;
    last_d  = 1'b0;
    empty_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_rd_req) begin
          count_d = acc_n;
          if (acc_n == '0) begin
            empty_d = 1'b1;
          end else begin
            state_d = READ;
            base_d  = acc_base;
            addr_d  = acc_base + ADDR_W'(acc_start);
            idx_d   = inc_wrap(acc_start);
            rem_d   = acc_n - CW'(1);
            rd_en_d = 1'b1;
          end
        end
      end
      READ: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
          last_d  = 1'b1;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = base_q + ADDR_W'(idx_q);
          idx_d   = inc_wrap(idx_q);
          rem_d   = rem_q - CW'(1);
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // controller state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      rd_en_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      rd_en_q <= rd_en_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      empty_q <= empty_d;
    end
  end

  // RAM data lands one cycle after the strobe
  always_comb begin
    o_rd_ready     = (state_q == IDLE);
    o_mem_rd_en    = rd_en_q;
    o_mem_addr     = addr_q;
    o_sample_valid = vld_q;
    o_sample       = vld_q ? i_mem_rdata : '0;
    o_sample_last  = last_q;
    o_done         = last_q | empty_q;
    o_count        = count_q;
  end

endmodule

// File: tb/tb_volatility_rd_ctrl.sv
// Directed bench for volatility_rd_ctrl with a
// behavioural RAM and writer driven from stimulus.
module tb_volatility_rd_ctrl;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_wr_valid;
  logic [1:0]  i_wr_stock_id;
  logic        i_rd_req;
  logic [1:0]  i_rd_stock_id;
  logic        o_rd_ready;
  logic        o_mem_rd_en;
  logic [6:0]  o_mem_addr;
  logic [31:0] rdata;
  logic [31:0] o_sample;
  logic        o_sample_valid;
  logic        o_sample_last;
  logic [4:0]  o_count;
  logic        o_done;

  logic [31:0] mem [80];
  int checks   = 0;
  int failures = 0;
  int wcnt [4];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_mem_rd_en) rdata <= mem[o_mem_addr];

  volatility_rd_ctrl dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_wr_valid     (i_wr_valid),
    .i_wr_stock_id  (i_wr_stock_id),
    .i_rd_req       (i_rd_req),
    .i_rd_stock_id  (i_rd_stock_id),
    .o_rd_ready     (o_rd_ready),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rdata    (rdata),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_sample_last  (o_sample_last),
    .o_count        (o_count),
    .o_done         (o_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_setup(input int s);
    wcnt[s]++;
    mem[s*20 + (wcnt[s]-1) % 20] = s*1000 + wcnt[s];
    i_wr_valid    = 1'b1;
    i_wr_stock_id = 2'(s);
  endtask

  task automatic wr(input int s);
    wr_setup(s);
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ready"}, o_rd_ready, 1);
    chk({p, "_rd_en"}, o_mem_rd_en, 0);
    chk({p, "_addr"}, o_mem_addr, 0);
    chk({p, "_valid"}, o_sample_valid, 0);
    chk({p, "_sample"}, o_sample, 0);
    chk({p, "_last"}, o_sample_last, 0);
    chk({p, "_done"}, o_done, 0);
    chk({p, "_count"}, o_count, 0);
  endtask

  task automatic run_empty(input int s);
    i_rd_stock_id = 2'(s);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("empty_done", o_done, 1);
    chk("empty_ready", o_rd_ready, 1);
    chk("empty_count", o_count, 0);
    chk("empty_rd_en", o_mem_rd_en, 0);
    chk("empty_valid", o_sample_valid, 0);
    tick();
    chk("empty_done_clr", o_done, 0);
  endtask

  task automatic run_read(input int s,
                          input int n,
                          input int start,
                          input int first_seq,
                          input bit same_wr,
                          input bit busy);
    i_rd_stock_id = 2'(s);
    i_rd_req = 1'b1;
    if (same_wr) wr_setup(s);
    chk("ready_pre", o_rd_ready, 1);
    tick();
    i_rd_req   = 1'b0;
    i_wr_valid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      if (busy && k < n) begin
        i_rd_req = 1'b1;
        i_rd_stock_id = 2'd2;
      end else begin
        i_rd_req = 1'b0;
        i_rd_stock_id = 2'(s);
      end
      chk("busy_ready", o_rd_ready, 0);
      chk("count", o_count, n);
      chk("rd_en", o_mem_rd_en, k < n);
      if (k < n)
        chk("addr", o_mem_addr,
            s*20 + (start + k) % 20);
      chk("valid", o_sample_valid, k > 0);
      if (k > 0)
        chk("sample", o_sample,
            s*1000 + first_seq + k - 1);
      chk("last", o_sample_last, k == n);
      chk("done", o_done, k == n);
      tick();
    end
    i_rd_req = 1'b0;
    chk("ready_post", o_rd_ready, 1);
    chk("done_post", o_done, 0);
    chk("valid_post", o_sample_valid, 0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) wcnt[s] = 0;
    i_reset_n     = 1'b0;
    i_wr_valid    = 1'b0;
    i_wr_stock_id = 2'd0;
    i_rd_req      = 1'b0;
    i_rd_stock_id = 2'd0;
    tick();
    tick();
    chk_reset_vals("rst");
    i_reset_n = 1'b1;
    tick();

    run_empty(2);

    repeat (3) wr(1);
    run_read(1, 3, 0, 1, 1'b0, 1'b0);

    repeat (25) wr(0);
    run_read(0, 20, 5, 6, 1'b0, 1'b0);

    repeat (20) wr(3);
    run_read(3, 20, 1, 2, 1'b1, 1'b0);

    run_read(1, 3, 0, 1, 1'b0, 1'b1);
    run_read(1, 3, 0, 1, 1'b0, 1'b0);

    repeat (10) wr(2);
    i_rd_stock_id = 2'd2;
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("mid_count", o_count, 10);
    chk("mid_addr0", o_mem_addr, 40);
    tick();
    chk("mid_valid", o_sample_valid, 1);
    chk("mid_sample0", o_sample, 2001);
    tick();
    i_reset_n = 1'b0;
    chk("mid_sample1", o_sample, 2002);
    tick();
    chk_reset_vals("midrst");
    i_reset_n = 1'b1;
    for (int s = 0; s < 4; s++) wcnt[s] = 0;
    for (int c = 0; c < 12; c++) begin
      chk("post_rst_done", o_done, 0);
      chk("post_rst_valid", o_sample_valid, 0);
      tick();
    end

    for (int s = 0; s < 4; s++) run_empty(s);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
